// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: instruction sequencer with an internal T-step counter,
// per-step datapath strobes for a small register file, and memory handshake stalls.
// Optional memory-wait watchdog: define CTRL_SEQ_WDT_EN.
module ctrl_sequencer #(
  parameter int DATA_W     = 19,
  parameter int NUM_REGS   = 4,
  parameter int T_STATES   = 8,
  parameter int WDT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   ir,
  input  logic                eq,
  input  logic                mem_ack,
  output logic [T_STATES-1:0] t,
  output logic                ld_ar,
  output logic                ld_pc,
  output logic                inc_pc,
  output logic                ld_dr,
  output logic                ld_ac,
  output logic                ld_ir,
  output logic [NUM_REGS-1:0] ld_reg,
  output logic [NUM_REGS-1:0] inc_reg,
  output logic [NUM_REGS-1:0] dec_reg,
  output logic [4:0]          bus_sel,
  output logic [3:0]          alu_op,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                stk_push,
  output logic                stk_pop,
  output logic                halted,
  output logic                bus_err
);
  localparam int RS  = $clog2(NUM_REGS);
  localparam int SCW = $clog2(T_STATES);

  localparam logic [4:0] BUS_AR = 5'd1, BUS_PC = 5'd2, BUS_AC = 5'd4;
  localparam logic [4:0] BUS_IR = 5'd6, BUS_MEM = 5'd7, BUS_STK = 5'd8;
  localparam logic [3:0] ALU_NOT = 4'd10, ALU_TNF = 4'd15;
  localparam logic [2:0] OP_HLT = 3'd0, OP_JMP = 3'd1, OP_CALL = 3'd2, OP_LD = 3'd3;
  localparam logic [2:0] OP_ST = 3'd4, OP_BEQ = 3'd5, OP_BNE = 3'd6, OP_REG = 3'd7;
  localparam logic [3:0] SUB_INC = 4'd5, SUB_DEC = 4'd6, SUB_NOT = 4'd10, SUB_RET = 4'd14;
  localparam logic [SCW-1:0] T0 = SCW'(0), T1 = SCW'(1), T2 = SCW'(2), T3 = SCW'(3);
  localparam logic [SCW-1:0] T4 = SCW'(4), T5 = SCW'(5), T6 = SCW'(6);
  localparam logic [SCW-1:0] TLAST = SCW'(T_STATES - 1);

  typedef enum logic {RUN, HALT} state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic           bus_err_q, bus_err_d;
  logic           clr, stall, mem_step;

  logic [2:0]    opcode;
  logic [3:0]    sub_op;
  logic [RS-1:0] dst, s1, s2;

  assign opcode = ir[DATA_W-1 -: 3];
  assign sub_op = ir[DATA_W-4 -: 4];
  assign dst    = ir[11 -: RS];
  assign s1     = ir[11-RS -: RS];
  assign s2     = ir[11-2*RS -: RS];

  // Only some IR bits are decoded, and the watchdog limit is meaningless without the watchdog.
  logic        unused_ir;
  logic [31:0] unused_wdt;
  assign unused_ir  = ^ir;
  assign unused_wdt = WDT_CYCLES;

  // One-hot register select; out-of-range field values select nothing.
  function automatic logic [NUM_REGS-1:0] reg_oh(input logic [RS-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i] = (idx == RS'(i));
    return v;
  endfunction

  function automatic logic [4:0] reg_bus(input logic [RS-1:0] idx);
    return (|reg_oh(idx)) ? {1'b1, 4'(idx)} : 5'd0;
  endfunction

`ifdef CTRL_SEQ_WDT_EN
  localparam int WCW = $clog2(WDT_CYCLES + 1);
  logic [WCW-1:0] wcnt_q, wcnt_d;

  // Watchdog wait counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end
`endif

  // State, step counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      sc_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Step decode, strobe generation, stall and next-state logic.
  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    bus_err_d = bus_err_q;
    clr       = 1'b0;
    stall     = 1'b0;
    mem_step  = 1'b0;
    t         = '0;
    ld_ar     = 1'b0;
    ld_pc     = 1'b0;
    inc_pc    = 1'b0;
    ld_dr     = 1'b0;
    ld_ac     = 1'b0;
    ld_ir     = 1'b0;
    ld_reg    = '0;
    inc_reg   = '0;
    dec_reg   = '0;
    bus_sel   = '0;
    alu_op    = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    halted    = 1'b0;
    bus_err   = 1'b0;
`ifdef CTRL_SEQ_WDT_EN
    wcnt_d    = '0;
`endif
    if (rst_n) begin
      halted  = (state_q == HALT);
      bus_err = bus_err_q;
      if (state_q == RUN) begin
        for (int i = 0; i < T_STATES; i++) t[i] = (sc_q == SCW'(i));
        if (sc_q == T0) begin
          bus_sel = BUS_PC; ld_ar = 1'b1;
        end else if (sc_q == T1) begin
          mem_step = 1'b1; mem_rd = 1'b1; bus_sel = BUS_MEM;
          if (mem_ack) begin ld_ir = 1'b1; inc_pc = 1'b1; end
        end else begin
          case (opcode)
            OP_HLT: if (sc_q == T2) begin state_d = HALT; clr = 1'b1; end
            OP_REG: begin
              case (sub_op)
                4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9: begin
                  if (sc_q == T2)      begin bus_sel = reg_bus(s1); ld_dr = 1'b1; end
                  else if (sc_q == T3) begin alu_op = ALU_TNF; ld_ac = 1'b1; end
                  else if (sc_q == T4) begin bus_sel = reg_bus(s2); ld_dr = 1'b1; end
                  else if (sc_q == T5) begin alu_op = sub_op; ld_ac = 1'b1; end
                  else if (sc_q == T6) begin bus_sel = BUS_AC; ld_reg = reg_oh(dst); clr = 1'b1; end
                end
                SUB_INC: if (sc_q == T2) begin inc_reg = reg_oh(dst); clr = 1'b1; end
                SUB_DEC: if (sc_q == T2) begin dec_reg = reg_oh(dst); clr = 1'b1; end
                SUB_NOT: begin
                  if (sc_q == T2)      begin bus_sel = reg_bus(s1); ld_dr = 1'b1; end
                  else if (sc_q == T3) begin alu_op = ALU_NOT; ld_ac = 1'b1; end
                  else if (sc_q == T4) begin bus_sel = BUS_AC; ld_reg = reg_oh(dst); clr = 1'b1; end
                end
                SUB_RET: if (sc_q == T2) begin stk_pop = 1'b1; bus_sel = BUS_STK; ld_pc = 1'b1; clr = 1'b1; end
                default: if (sc_q == T2) clr = 1'b1;
              endcase
            end
            default: begin
              if (sc_q == T2) begin
                bus_sel = BUS_IR; ld_ar = 1'b1;
              end else begin
                case (opcode)
                  OP_JMP: if (sc_q == T3) begin bus_sel = BUS_AR; ld_pc = 1'b1; clr = 1'b1; end
                  OP_CALL: begin
                    if (sc_q == T3)      begin bus_sel = BUS_PC; stk_push = 1'b1; end
                    else if (sc_q == T4) begin bus_sel = BUS_AR; ld_pc = 1'b1; clr = 1'b1; end
                  end
                  OP_LD: if (sc_q == T3) begin
                    mem_step = 1'b1; mem_rd = 1'b1; bus_sel = BUS_MEM;
                    if (mem_ack) begin ld_reg = reg_oh(dst); clr = 1'b1; end
                  end
                  OP_ST: if (sc_q == T3) begin
                    mem_step = 1'b1; mem_wr = 1'b1; bus_sel = reg_bus(dst);
                    if (mem_ack) clr = 1'b1;
                  end
                  OP_BEQ, OP_BNE: begin
                    if (sc_q == T3)      begin bus_sel = reg_bus(dst); ld_dr = 1'b1; end
                    else if (sc_q == T4) begin alu_op = ALU_TNF; ld_ac = 1'b1; end
                    else if (sc_q == T5) begin bus_sel = reg_bus(s1); ld_dr = 1'b1; end
                    else if (sc_q == T6) begin
                      if (eq == (opcode == OP_BEQ)) begin bus_sel = BUS_AR; ld_pc = 1'b1; end
                      clr = 1'b1;
                    end
                  end
                  default: ;
                endcase
              end
            end
          endcase
        end
        if (sc_q == TLAST) clr = 1'b1;
        stall = mem_step && !mem_ack;
`ifdef CTRL_SEQ_WDT_EN
        if (stall) begin
          if (wcnt_q == WCW'(WDT_CYCLES - 1)) begin
            bus_err_d = 1'b1;
            state_d   = HALT;
            clr       = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
`endif
        if (clr)         sc_d = '0;
        else if (!stall) sc_d = sc_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: randomized instruction stream checked cycle by cycle against
// a micro-op list model of each instruction, plus directed reset/halt/stall cases.
module tb_ctrl_sequencer;
  localparam int DATA_W = 19, NUM_REGS = 4, T_STATES = 8, WDT_CYCLES = 4;

  logic clk, rst_n, eq, mem_ack;
  logic [DATA_W-1:0] ir;
  logic [T_STATES-1:0] t;
  logic ld_ar, ld_pc, inc_pc, ld_dr, ld_ac, ld_ir;
  logic [NUM_REGS-1:0] ld_reg, inc_reg, dec_reg;
  logic [4:0] bus_sel;
  logic [3:0] alu_op;
  logic mem_rd, mem_wr, stk_push, stk_pop, halted, bus_err;

  ctrl_sequencer #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .T_STATES(T_STATES), .WDT_CYCLES(WDT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .eq(eq), .mem_ack(mem_ack), .t(t),
    .ld_ar(ld_ar), .ld_pc(ld_pc), .inc_pc(inc_pc), .ld_dr(ld_dr), .ld_ac(ld_ac), .ld_ir(ld_ir),
    .ld_reg(ld_reg), .inc_reg(inc_reg), .dec_reg(dec_reg), .bus_sel(bus_sel), .alu_op(alu_op),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .stk_push(stk_push), .stk_pop(stk_pop),
    .halted(halted), .bus_err(bus_err)
  );

  typedef struct packed {
    logic [T_STATES-1:0] t;
    logic ld_ar, ld_pc, inc_pc, ld_dr, ld_ac, ld_ir;
    logic [NUM_REGS-1:0] ld_reg, inc_reg, dec_reg;
    logic [4:0] bus_sel;
    logic [3:0] alu_op;
    logic mem_rd, mem_wr, stk_push, stk_pop, halted, bus_err;
  } out_t;

  out_t obs;
  out_t exp_q[$];
  logic ack_q[$];
  int vectors = 0;
  int miscompares = 0;

  assign obs = {t, ld_ar, ld_pc, inc_pc, ld_dr, ld_ac, ld_ir, ld_reg, inc_reg, dec_reg,
                bus_sel, alu_op, mem_rd, mem_wr, stk_push, stk_pop, halted, bus_err};

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  function automatic out_t at_step(input int s);
    out_t o;
    o = '0;
    o.t[s] = 1'b1;
    return o;
  endfunction

  function automatic logic [NUM_REGS-1:0] reg_bit(input int r);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  function automatic logic [4:0] reg_bus(input int r);
    return 5'(16 + r);
  endfunction

  function automatic logic [DATA_W-1:0] make_ir(input int opc, input int sub, input int dst, input int s1, input int s2);
    logic [DATA_W-1:0] v;
    v = DATA_W'($urandom);
    v[18:16] = 3'(opc);
    v[15:12] = 4'(sub);
    v[11:10] = 2'(dst);
    v[9:8]   = 2'(s1);
    v[7:6]   = 2'(s2);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input out_t expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic add_cycle(input out_t o, input logic ack);
    exp_q.push_back(o);
    ack_q.push_back(ack);
  endtask

  // A memory step: held outputs during waits, extra strobes only with the ack.
  task automatic add_mem(input out_t held, input out_t on_ack, input int waits);
    for (int i = 0; i < waits; i++) add_cycle(held, 1'b0);
    add_cycle(held | on_ack, 1'b1);
  endtask

  // Expected cycle list for one whole instruction, fetch included.
  task automatic build_instr(input int opc, input int sub, input int dst, input int s1, input int s2,
                             input logic eqv, input int fw, input int mw);
    out_t o, x;
    o = at_step(0); o.bus_sel = 5'd2; o.ld_ar = 1'b1; add_cycle(o, rnd_bit());
    o = at_step(1); o.mem_rd = 1'b1; o.bus_sel = 5'd7;
    x = '0; x.ld_ir = 1'b1; x.inc_pc = 1'b1;
    add_mem(o, x, fw);
    if (opc >= 1 && opc <= 6) begin
      o = at_step(2); o.bus_sel = 5'd6; o.ld_ar = 1'b1; add_cycle(o, rnd_bit());
    end
    case (opc)
      0: add_cycle(at_step(2), rnd_bit());
      1: begin o = at_step(3); o.bus_sel = 5'd1; o.ld_pc = 1'b1; add_cycle(o, rnd_bit()); end
      2: begin
        o = at_step(3); o.bus_sel = 5'd2; o.stk_push = 1'b1; add_cycle(o, rnd_bit());
        o = at_step(4); o.bus_sel = 5'd1; o.ld_pc = 1'b1; add_cycle(o, rnd_bit());
      end
      3: begin
        o = at_step(3); o.mem_rd = 1'b1; o.bus_sel = 5'd7;
        x = '0; x.ld_reg = reg_bit(dst);
        add_mem(o, x, mw);
      end
      4: begin
        o = at_step(3); o.mem_wr = 1'b1; o.bus_sel = reg_bus(dst);
        add_mem(o, '0, mw);
      end
      5, 6: begin
        o = at_step(3); o.bus_sel = reg_bus(dst); o.ld_dr = 1'b1; add_cycle(o, rnd_bit());
        o = at_step(4); o.alu_op = 4'd15; o.ld_ac = 1'b1; add_cycle(o, rnd_bit());
        o = at_step(5); o.bus_sel = reg_bus(s1); o.ld_dr = 1'b1; add_cycle(o, rnd_bit());
        o = at_step(6);
        if ((opc == 5) == eqv) begin o.bus_sel = 5'd1; o.ld_pc = 1'b1; end
        add_cycle(o, rnd_bit());
      end
      default: begin
        if (sub inside {1, 2, 3, 4, 7, 8, 9}) begin
          o = at_step(2); o.bus_sel = reg_bus(s1); o.ld_dr = 1'b1; add_cycle(o, rnd_bit());
          o = at_step(3); o.alu_op = 4'd15; o.ld_ac = 1'b1; add_cycle(o, rnd_bit());
          o = at_step(4); o.bus_sel = reg_bus(s2); o.ld_dr = 1'b1; add_cycle(o, rnd_bit());
          o = at_step(5); o.alu_op = 4'(sub); o.ld_ac = 1'b1; add_cycle(o, rnd_bit());
          o = at_step(6); o.bus_sel = 5'd4; o.ld_reg = reg_bit(dst); add_cycle(o, rnd_bit());
        end else if (sub == 5) begin
          o = at_step(2); o.inc_reg = reg_bit(dst); add_cycle(o, rnd_bit());
        end else if (sub == 6) begin
          o = at_step(2); o.dec_reg = reg_bit(dst); add_cycle(o, rnd_bit());
        end else if (sub == 10) begin
          o = at_step(2); o.bus_sel = reg_bus(s1); o.ld_dr = 1'b1; add_cycle(o, rnd_bit());
          o = at_step(3); o.alu_op = 4'd10; o.ld_ac = 1'b1; add_cycle(o, rnd_bit());
          o = at_step(4); o.bus_sel = 5'd4; o.ld_reg = reg_bit(dst); add_cycle(o, rnd_bit());
        end else if (sub == 14) begin
          o = at_step(2); o.stk_pop = 1'b1; o.bus_sel = 5'd8; o.ld_pc = 1'b1; add_cycle(o, rnd_bit());
        end else begin
          add_cycle(at_step(2), rnd_bit());
        end
      end
    endcase
  endtask

  // Plays queued cycles (up to max_cycles), checking each one mid-cycle, then drops the rest.
  task automatic applyStimulus(input string tag, input int max_cycles);
    int n;
    out_t e;
    n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      e = exp_q.pop_front();
      mem_ack = ack_q.pop_front();
      @(negedge clk);
      checkOutput(tag, e);
      @(posedge clk); #1;
      n++;
    end
    exp_q.delete();
    ack_q.delete();
  endtask

  task automatic run_instr(input string tag, input int opc, input int sub, input int dst, input int s1,
                           input int s2, input logic eqv, input int fw, input int mw);
    ir = make_ir(opc, sub, dst, s1, s2);
    eq = eqv;
    build_instr(opc, sub, dst, s1, s2, eqv, fw, mw);
    applyStimulus(tag, 100);
  endtask

  // Holds reset for n edges with a stray ack present; every output must read 0.
  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("reset", '0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    mem_ack = 1'b0;
  endtask

  task automatic expect_halted(input int n, input logic berr);
    out_t o;
    o = '0;
    o.halted = 1'b1;
    o.bus_err = berr;
    for (int i = 0; i < n; i++) begin
      mem_ack = rnd_bit();
      @(negedge clk);
      checkOutput("halt", o);
      @(posedge clk); #1;
    end
  endtask

  // Directed sequence followed by a randomized instruction stream.
  initial begin
    out_t o;
    rst_n = 1'b0; mem_ack = 1'b0; eq = 1'b0; ir = '0;
    @(posedge clk); #1;
    apply_reset(2);

    run_instr("fetch_wait", 1, 0, 0, 0, 0, 1'b0, 2, 0);
    run_instr("add_seq", 7, 1, 2, 0, 1, 1'b0, 0, 0);
    run_instr("beq_not_taken", 5, 0, 1, 3, 0, 1'b0, 0, 0);
    run_instr("bne_taken", 6, 0, 2, 1, 0, 1'b0, 1, 0);
    run_instr("ld_min_ack", 3, 0, 3, 0, 0, 1'b0, 0, 0);
    run_instr("st_wait", 4, 0, 1, 0, 0, 1'b0, 0, 2);

    for (int k = 0; k < 60; k++) begin
      run_instr("random", int'($urandom_range(7, 1)), int'($urandom_range(15, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                rnd_bit(), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
    end

    ir = make_ir(3, 0, 1, 0, 0);
    eq = 1'b0;
    build_instr(3, 0, 1, 0, 0, 1'b0, 0, 6);
    applyStimulus("ld_stall", 5);
    apply_reset(1);
    run_instr("after_reset", 2, 0, 0, 0, 0, 1'b0, 0, 0);

    run_instr("hlt", 0, 0, 0, 0, 0, 1'b0, 1, 0);
    expect_halted(20, 1'b0);
    apply_reset(1);
    run_instr("resume", 7, 14, 0, 0, 0, 1'b0, 0, 0);

`ifdef CTRL_SEQ_WDT_EN
    ir = make_ir(1, 0, 0, 0, 0);
    o = at_step(0); o.bus_sel = 5'd2; o.ld_ar = 1'b1; add_cycle(o, 1'b0);
    o = at_step(1); o.mem_rd = 1'b1; o.bus_sel = 5'd7;
    for (int i = 0; i < WDT_CYCLES; i++) add_cycle(o, 1'b0);
    applyStimulus("wdt_stall", 100);
    expect_halted(3, 1'b1);
    apply_reset(1);
    run_instr("wdt_cleared", 7, 5, 1, 0, 0, 1'b0, 0, 0);
`else
    o = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised successor to the CPU's combinational control decoder. It owns the sequence counter, so T-steps are generated internally rather than supplied as inputs. It decodes the instruction register, generates per-step datapath strobes for a configurable register file, and stalls on a memory request/acknowledge handshake. It sits between the IR/flag outputs of the datapath and every load, increment, bus-select and ALU control input.

## Interface
- `DATA_W`, 19: IR width; opcode is `ir[DATA_W-1 -: 3]`, sub-opcode is `ir[DATA_W-4 -: 4]`.
- `NUM_REGS`, 4: general registers (2..16); `RS = clog2(NUM_REGS)`.
- `T_STATES`, 8: sequence counter length (≥7).
- `WDT_CYCLES`, 64: memory-wait watchdog limit (used only with the watchdog macro).
- `clk`, in, 1: clock; all state changes on rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `ir`, in, DATA_W: instruction register contents.
- `eq`, in, 1: DR==AC from the equality detector.
- `mem_ack`, in, 1: memory completes current request.
- `t`, out, T_STATES: one-hot current T-step.
- `ld_ar` / `ld_pc` / `inc_pc` / `ld_dr` / `ld_ac` / `ld_ir`, out, 1 each: register strobes.
- `ld_reg`, `inc_reg`, `dec_reg`, out, NUM_REGS each: per-register strobes, at most one bit high per bus.
- `bus_sel`, out, 5: 0 none, 1 AR, 2 PC, 4 AC, 6 IR, 7 MEM, 8 STK, 16+i REG i.
- `alu_op`, out, 4: 0 none, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 7 AND, 8 OR, 9 XOR, 10 NOT, 15 TNF.
- `mem_rd`, `mem_wr`, `stk_push`, `stk_pop`, out, 1 each.
- `halted`, out, 1: sequencer in HALT.
- `bus_err`, out, 1: watchdog trip, sticky until reset. Tied 0 without the watchdog macro.

## Operation
- Register fields: `dst = ir[11 -: RS]`, `s1 = ir[11-RS -: RS]`, `s2 = ir[11-2RS -: RS]`.
- Field values ≥ NUM_REGS select nothing: no strobe and bus_sel 0 for that step.
- States: RUN, HALT. `sc` advances each RUN cycle unless stalled or cleared. A clear returns `sc` to 0 (T0) on the next edge.

Fetch:
- T0: bus_sel=PC, ld_ar.
- T1: memory step; mem_rd, bus_sel=MEM, ld_ir, inc_pc.

Execute, selected by opcode at T2:
- 0 HLT: T2 → HALT.
- 1 JMP:
  - T2: bus IR, ld_ar.
  - T3: bus AR, ld_pc, clear.
- 2 CALL:
  - T2: bus IR, ld_ar.
  - T3: bus PC, stk_push.
  - T4: bus AR, ld_pc, clear.
- 3 LD:
  - T2: bus IR, ld_ar.
  - T3: memory step; mem_rd, bus MEM, ld_reg[dst], clear.
- 4 ST:
  - T2: bus IR, ld_ar.
  - T3: memory step; mem_wr, bus REG dst, clear.
- 5 BEQ / 6 BNE:
  - T2: bus IR, ld_ar.
  - T3: bus REG dst, ld_dr.
  - T4: alu TNF, ld_ac.
  - T5: bus REG s1, ld_dr.
  - T6: if (eq for 5, !eq for 6) bus AR, ld_pc; clear either way.
- 7 register ops, by sub-opcode:
  - 1–4, 7–9:
    - T2: bus REG s1, ld_dr.
    - T3: TNF, ld_ac.
    - T4: bus REG s2, ld_dr.
    - T5: alu_op=sub, ld_ac.
    - T6: bus AC, ld_reg[dst], clear.
  - 5 INC / 6 DEC: T2: inc_reg/dec_reg[dst], clear.
  - 10 NOT:
    - T2: bus REG s1, ld_dr.
    - T3: NOT, ld_ac.
    - T4: bus AC, ld_reg[dst], clear.
  - 14 RET: T2: stk_pop, bus STK, ld_pc, clear.
  - Others: NOP, clear at T2.
- `sc` reaching T_STATES-1 without a clear forces a clear (wrap to T0); no strobes in that step.

## Timing
- Reset, `rst_n` low at an edge:
  - On that edge: sc=0, state RUN, bus_err=0.
  - During the cycles `rst_n` is low, every output is 0, including `t`.
  - First cycle after release: T0 strobes.
  - Reset mid-instruction or mid-stall aborts it with no further strobes.
- Memory step:
  - mem_rd/mem_wr and bus_sel are held for the whole step.
  - `sc` holds while mem_ack=0.
  - Load/inc/stk strobes of that step assert only in the cycle mem_ack=1.
  - Minimum step is 1 cycle (ack in first cycle).
  - mem_ack outside a memory step is ignored.
- Non-memory steps last exactly 1 cycle; strobes are combinational from registered `sc`, `ir`, `eq`.
- Instruction length in cycles, with a 1-cycle ack:
  - JMP 4, CALL 5, LD 4, ST 4, BEQ/BNE 7.
  - ALU 7, INC/DEC 3, NOT 5, RET 3.
- HALT:
  - All strobes 0, `t`=0, halted=1.
  - Left only by reset.

## Configuration
- `CTRL_SEQ_WDT_EN` defined:
  - A wait counter clears at each memory step entry.
  - When WDT_CYCLES consecutive cycles pass without mem_ack, it sets bus_err and drops mem_rd/mem_wr.
  - Next state is HALT.
- Undefined: no counter, bus_err=0, stalls are unbounded.

## Test plan
- Reset then fetch with ack after 3 cycles: T0 ld_ar, T1 mem_rd held for 3 cycles, ld_ir/inc_pc pulse only in the ack cycle, then `t`=T2.
- ir=7/ADD, dst=2, s1=0, s2=1: sequence bus 16, TNF, bus 17, alu_op 1, then ld_reg=4'b0100 at T6; back to T0 after 7 cycles total.
- BEQ with eq=0, then BNE with eq=0: first gives no ld_pc at T6; second gives ld_pc with bus_sel=1; both clear.
- HLT: halted=1 from the cycle after T2, all strobes 0 for 20 cycles; rst_n low resumes at T0.
- Reset asserted during a LD T3 stall: all outputs 0 next cycle, T0 after release, no ld_reg pulse.
- `CTRL_SEQ_WDT_EN`, WDT_CYCLES=4, mem_ack held 0 in T1: bus_err=1 after 4 cycles, mem_rd drops, halted=1.
